// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types for the FIFO write-port arbiter.
// Holds FSM state encoding and the tag placement of written words.
package fifo_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Requester index sits above the payload in every FIFO word.
  localparam bit TAG_IN_MSB = 1'b1;

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Rotating-priority encoder: first requester after the pointer wins.
// Purely combinational.
module rr_priority_picker #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [LOG_NUM_REQ-1:0] rr_ptr,
  output logic [LOG_NUM_REQ-1:0] winner,
  output logic                   any_valid
);

  always_comb begin
    winner    = '0;
    any_valid = |req;
    // Walk from farthest to nearest so the nearest hit overwrites.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        winner = LOG_NUM_REQ'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// Words are tagged with the requester index and written one cycle later.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int LOG_NUM_REQ   = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_BURST     = 4,
  parameter int LOG_MAX_BURST = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [LOG_NUM_REQ+DATA_WIDTH-1:0] fifo_data_write,
  output logic                            fifo_write,
  input  logic                            fifo_full,
  input  logic                            fifo_almost_full
);

  localparam int CNT_W = (LOG_MAX_BURST < 1) ? 1 : LOG_MAX_BURST;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [LOG_NUM_REQ-1:0] PTR_RST = LOG_NUM_REQ'(NUM_REQ - 1);

  arb_state_e state, state_nx;
  logic [LOG_NUM_REQ-1:0] rr_ptr, rr_nx;
  logic [LOG_NUM_REQ-1:0] owner, owner_nx;
  logic [CNT_W-1:0] burst_cnt, cnt_nx;

  logic [LOG_NUM_REQ-1:0] winner;
  logic any_valid;
  logic can_issue;
  logic acc;
  logic [LOG_NUM_REQ-1:0] acc_idx;
  logic [NUM_REQ-1:0] ready_c;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [LOG_NUM_REQ+DATA_WIDTH-1:0] word_c;

  // A write already registered is not yet reflected in almost_full.
  assign can_issue = ~fifo_full & ~(fifo_almost_full & fifo_write);

  rr_priority_picker #(
    .NUM_REQ    (NUM_REQ),
    .LOG_NUM_REQ(LOG_NUM_REQ)
  ) u_picker (
    .req      (req_valid),
    .rr_ptr   (rr_ptr),
    .winner   (winner),
    .any_valid(any_valid)
  );

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    owner_nx = owner;
    cnt_nx   = burst_cnt;
    ready_c  = '0;
    acc      = 1'b0;
    acc_idx  = owner;
    unique case (state)
      ST_IDLE: begin
        if (any_valid && can_issue) begin
          acc             = 1'b1;
          acc_idx         = winner;
          owner_nx        = winner;
          ready_c[winner] = 1'b1;
          if (MAX_BURST == 1) begin
            rr_nx  = winner;
            cnt_nx = '0;
          end else begin
            cnt_nx   = CNT_W'(1);
            state_nx = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (!req_valid[owner]) begin
          state_nx = ST_IDLE;
          rr_nx    = owner;
          cnt_nx   = '0;
        end else if (can_issue) begin
          acc            = 1'b1;
          ready_c[owner] = 1'b1;
          if (burst_cnt == CNT_LAST) begin
            state_nx = ST_IDLE;
            rr_nx    = owner;
            cnt_nx   = '0;
          end else begin
            cnt_nx = burst_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign req_ready = rst ? '0 : ready_c;

  assign acc_data = req_data[acc_idx*DATA_WIDTH +: DATA_WIDTH];
  assign word_c   = TAG_IN_MSB ? {acc_idx, acc_data} : {acc_data, acc_idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= PTR_RST;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      owner     <= owner_nx;
      burst_cnt <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_write      <= 1'b0;
      fifo_data_write <= '0;
    end else begin
      fifo_write <= acc;
      if (acc) fifo_data_write <= word_c;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed checks of fifo_write_arbiter.
// Uses a per-cycle behavioural model plus a bench-side FIFO.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [9:0]  fifo_data_write;
  logic        fifo_write;
  logic        fifo_full;
  logic        fifo_almost_full;

  fifo_write_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_data_write (fifo_data_write),
    .fifo_write      (fifo_write),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench FIFO: occupancy only, capacity set per phase.
  int depth = 1000;
  int fcount = 0;
  int nwrites = 0;
  bit fifo_rd = 0;
  bit force_full = 0;

  assign fifo_full        = force_full || (fcount >= depth);
  assign fifo_almost_full = (fcount == depth - 1);

  always @(posedge clk) begin
    if (rst) begin
      fcount  <= 0;
      nwrites <= 0;
    end else begin
      fcount  <= fcount + (fifo_write ? 1 : 0)
                 - ((fifo_rd && fcount > 0) ? 1 : 0);
      nwrites <= nwrites + (fifo_write ? 1 : 0);
    end
  end

  // Behavioural model: who holds the grant, words taken, last owner.
  int holder = -1;
  int taken = 0;
  int last = 3;
  bit m_fw = 0;
  logic [9:0] m_fdw = '0;
  logic [3:0] acc_mask = '0;
  int n_acc = 0;
  int cyc = 0;
  int log_idx[$];
  int log_cyc[$];

  always @(negedge clk) begin
    logic [3:0] er;
    bit can;
    bit found;
    int w;
    cyc++;
    if (rst) begin
      chk("rst_fifo_write", 32'(fifo_write), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_fifo_data", 32'(fifo_data_write), 0);
      holder = -1; taken = 0; last = 3;
      m_fw = 0; m_fdw = '0; acc_mask = '0; n_acc = 0;
      log_idx.delete(); log_cyc.delete();
    end else begin
      chk("fifo_write", 32'(fifo_write), 32'(m_fw));
      chk("fifo_data_write", 32'(fifo_data_write), 32'(m_fdw));
      chk("no_write_when_full", 32'(fifo_write && fcount >= depth), 0);
      er = '0; w = 0; found = 0;
      can = !fifo_full && !(fifo_almost_full && m_fw);
      if (holder < 0) begin
        if (can && req_valid != 0) begin
          for (int k = 1; k <= 4; k++) begin
            if (!found && req_valid[(last + k) % 4]) begin
              w = (last + k) % 4; found = 1;
            end
          end
          er[w] = 1'b1; holder = w; taken = 1;
        end
      end else if (!req_valid[holder]) begin
        last = holder; holder = -1;
      end else if (can) begin
        w = holder; er[w] = 1'b1; taken++;
        if (taken == 4) begin last = holder; holder = -1; end
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
      acc_mask = req_valid & req_ready;
      m_fw = (er != 0);
      if (er != 0) begin
        m_fdw = {2'(w), req_data[w*8 +: 8]};
        n_acc++;
        log_idx.push_back(w);
        log_cyc.push_back(cyc);
      end
    end
  end

  // Producers: pv = word pending, left = further words queued behind it.
  logic [3:0] pv = '0;
  logic [7:0] dat [4];
  int left [4];
  bit rand_mode = 0;
  bit rand_rd = 0;

  task automatic drive();
    req_valid = pv;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = dat[i];
  endtask

  task automatic load(input int i, input int n);
    pv[i] = 1'b1;
    dat[i] = 8'($urandom);
    left[i] = n - 1;
    drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc_mask[i]) begin
        if (left[i] > 0) begin
          left[i]--; dat[i] = 8'($urandom);
        end else begin
          pv[i] = 1'b0;
        end
      end
      if (rand_mode && !pv[i] && $urandom_range(0, 3) == 0) begin
        pv[i] = 1'b1; dat[i] = 8'($urandom);
        left[i] = $urandom_range(0, 6);
      end
    end
    if (rand_rd) fifo_rd = ($urandom_range(0, 1) == 1);
    drive();
  endtask

  task automatic do_reset(input int d);
    rst = 1'b1;
    pv = '0; force_full = 0; fifo_rd = 0; rand_mode = 0; rand_rd = 0;
    for (int i = 0; i < 4; i++) begin dat[i] = '0; left[i] = 0; end
    depth = d;
    drive();
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 4; i++) begin dat[i] = '0; left[i] = 0; end

    // Lone requester 2: bursts of 4 then 2 with no bubble.
    do_reset(1000);
    load(2, 6);
    repeat (12) tick();
    chk("p1_count", 32'(log_idx.size()), 6);
    for (int k = 0; k < 6; k++) chk("p1_idx", 32'(log_idx[k]), 2);
    chk("p1_span", 32'(log_cyc[5] - log_cyc[0]), 5);
    chk("p1_tag", 32'(fifo_data_write[9:8]), 2);
    chk("p1_writes", 32'(nwrites), 6);

    // Everyone busy: 0x4, 1x4, 2x4, 3x4, 0...
    do_reset(1000);
    for (int i = 0; i < 4; i++) load(i, 100);
    repeat (20) tick();
    for (int k = 0; k < 18; k++) chk("p2_order", 32'(log_idx[k]), 32'((k / 4) % 4));
    chk("p2_span", 32'(log_cyc[17] - log_cyc[0]), 17);

    // Four-slot FIFO, never read: exactly four writes land.
    do_reset(4);
    load(0, 50); load(1, 50);
    repeat (20) tick();
    chk("p3_writes", 32'(nwrites), 4);
    chk("p3_accepts", 32'(log_idx.size()), 4);
    chk("p3_fcount", 32'(fcount), 4);

    // Owner 1 runs dry after two words; 3 is next after a bubble.
    do_reset(1000);
    load(1, 2); load(3, 5);
    repeat (10) tick();
    chk("p4_first", 32'(log_idx[0]), 1);
    chk("p4_second", 32'(log_idx[1]), 1);
    chk("p4_third", 32'(log_idx[2]), 3);
    chk("p4_bubble", 32'(log_cyc[2] - log_cyc[1]), 2);

    // Reset in the middle of a burst with a write in flight.
    do_reset(1000);
    for (int i = 0; i < 4; i++) load(i, 100);
    repeat (6) tick();
    #2;
    chk("p5_pre_write", 32'(fifo_write), 1);
    rst = 1'b1;
    #1;
    chk("p5_write_drop", 32'(fifo_write), 0);
    chk("p5_ready_drop", 32'(req_ready), 0);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("p5_first_grant", 32'(log_idx[0]), 0);

    // Full for five cycles mid-burst: grant held, resumes at once.
    do_reset(1000);
    load(2, 8);
    tick(); tick();
    force_full = 1;
    repeat (5) tick();
    force_full = 0;
    repeat (12) tick();
    chk("p6_count", 32'(log_idx.size()), 8);
    chk("p6_owner", 32'(log_idx[2]), 2);
    chk("p6_resume", 32'(log_cyc[2] - log_cyc[1]), 6);
    chk("p6_span", 32'(log_cyc[7] - log_cyc[0]), 12);

    // Random traffic into a small FIFO with random reads.
    do_reset(4);
    rand_mode = 1; rand_rd = 1;
    repeat (3000) tick();
    rand_mode = 0; rand_rd = 0; fifo_rd = 1;
    guard = 0;
    while ((pv != 0 || fcount != 0 || fifo_write) && guard < 400) begin
      tick(); guard++;
    end
    chk("drain_pending", 32'(pv), 0);
    chk("drain_fifo", 32'(fcount), 0);
    chk("drain_writes", 32'(nwrites), 32'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
